pipelined_carry_adder: RTL

- Parametrised, pipelined ripple-chunk adder/subtractor: WIDTH-bit operands are split into STAGES equal chunks, and each pipeline stage adds one chunk with the registered carry from the previous stage.
- Valid/ready handshake on input and output, a registered carry-out and a signed-overflow flag.
- Single-cycle throughput; bounded critical path for wide datapaths.
- Generic arithmetic primitive for downstream datapath blocks that need more than a fixed 32-bit combinational add.

---
 rtl/adder_pkg.sv | 15 +
 rtl/add_chunk.sv | 18 +
 rtl/pipelined_carry_adder.sv | 131 +++++++++++++
 3 files changed

// File: rtl/adder_pkg.sv
// Shared types and helpers for the pipelined carry adder.
package adder_pkg;

  // Operation select: subtraction inverts b and the carry-in.
  typedef enum logic {
    OP_ADD = 1'b0,
    OP_SUB = 1'b1
  } op_e;

  // Chunk width handled by each pipeline stage.
  function automatic int chunk_width(input int width, input int stages);
    return width / stages;
  endfunction

endpackage

// File: rtl/add_chunk.sv
// Combinational CW-bit adder slice with carry in and carry out.
module add_chunk #(
  parameter int CW = 8
) (
  input  logic [CW-1:0] a,
  input  logic [CW-1:0] b,
  input  logic          cin,
  output logic [CW-1:0] sum,
  output logic          cout
);

  // One-chunk ripple add; the extra top bit is the chunk carry-out.
  // NOTE: every output is assigned on every path through this block, so no latch is inferred.
  always_comb begin
    {cout, sum} = {1'b0, a} + {1'b0, b} + {{CW{1'b0}}, cin};
  end

endmodule

// File: rtl/pipelined_carry_adder.sv
// Pipelined adder/subtractor: WIDTH bits split into STAGES chunks, one chunk
// per stage, with operand skew on the way in and sum deskew on the way out.
module pipelined_carry_adder
  import adder_pkg::*;
#(
  parameter int WIDTH  = 32,
  parameter int STAGES = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  op_e              op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             overflow
);

  localparam int CW   = chunk_width(WIDTH, STAGES);
  localparam int LAST = STAGES - 1;

  if (STAGES < 1 || STAGES > WIDTH || (WIDTH % STAGES) != 0) begin : g_bad_params
    $error("pipelined_carry_adder: WIDTH (%0d) must be a multiple of STAGES (%0d)", WIDTH, STAGES);
  end

  logic [WIDTH-1:0] b_eff;
  logic             cin_eff;
  logic             advance;

  // Subtraction is a + ~b + !cin, so only the b operand and carry-in change.
  assign b_eff   = (op == OP_SUB) ? ~b : b;
  assign cin_eff = (op == OP_SUB) ? ~cin : cin;

  // Global stall: the whole pipeline moves only when the output slot frees up.
  assign advance  = !g_stage[LAST].valid_q || out_ready;
  assign in_ready = advance;

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    // Remaining operand width entering this stage: chunks k..STAGES-1.
    localparam int IN_W = (STAGES - k) * CW;

    logic [IN_W-1:0]       a_in;
    logic [IN_W-1:0]       b_in;
    logic                  carry_in;
    logic                  valid_in;
    logic [CW-1:0]         chunk_sum;
    logic                  chunk_cout;
    logic [(k+1)*CW-1:0]   sum_nxt;
    logic                  valid_q;
    logic                  carry_q;
    logic [(k+1)*CW-1:0]   sum_q;

    if (k == 0) begin : g_head
      assign a_in     = a;
      assign b_in     = b_eff;
      assign carry_in = cin_eff;
      assign valid_in = in_valid;
      assign sum_nxt  = chunk_sum;
    end else begin : g_body
      assign a_in     = g_stage[k-1].g_skew.a_rem;
      assign b_in     = g_stage[k-1].g_skew.b_rem;
      assign carry_in = g_stage[k-1].carry_q;
      assign valid_in = g_stage[k-1].valid_q;
      // Completed lower chunks ride along underneath this stage's chunk.
      assign sum_nxt  = {chunk_sum, g_stage[k-1].sum_q};
    end

    add_chunk #(.CW(CW)) u_chunk (
      .a    (a_in[CW-1:0]),
      .b    (b_in[CW-1:0]),
      .cin  (carry_in),
      .sum  (chunk_sum),
      .cout (chunk_cout)
    );

    // Stage valid, carry and accumulated sum; data loads only for valid transactions.
    // NOTE: non-blocking assignments let each stage capture its neighbour's pre-edge value.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        // NOTE: data registers are reset too so sum/cout/overflow read 0 out of reset.
        valid_q <= 1'b0;
        carry_q <= 1'b0;
        sum_q   <= '0;
      end else if (advance) begin
        valid_q <= valid_in;
        if (valid_in) begin
          carry_q <= chunk_cout;
          sum_q   <= sum_nxt;
        end
      end
    end

    if (k < LAST) begin : g_skew
      logic [IN_W-CW-1:0] a_rem;
      logic [IN_W-CW-1:0] b_rem;

      // Carry the not-yet-added operand chunks (including sign bits) to later stages.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          a_rem <= '0;
          b_rem <= '0;
        end else if (advance && valid_in) begin
          a_rem <= a_in[IN_W-1:CW];
          b_rem <= b_in[IN_W-1:CW];
        end
      end
    end else begin : g_tail
      logic ovf_q;

      // Signed overflow: operands agree in sign but the result sign differs.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          ovf_q <= 1'b0;
        end else if (advance && valid_in) begin
          ovf_q <= (a_in[CW-1] == b_in[CW-1]) && (chunk_sum[CW-1] != a_in[CW-1]);
        end
      end
    end
  end

  assign out_valid = g_stage[LAST].valid_q;
  assign sum       = g_stage[LAST].sum_q;
  assign cout      = g_stage[LAST].carry_q;
  assign overflow  = g_stage[LAST].g_tail.ovf_q;

endmodule
